// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a first-word-fall-through instruction buffer
//
// Issues sequential word fetches to a one-cycle-latency instruction memory and
// queues the returned words, tagged with their fetch PC, in a small buffer.
// Redirects flush the buffer and restart fetching at the (word-aligned) target.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   imem_req      memory read strobe
//   imem_addr     memory read address (the fetch PC)
//   imem_rdata    memory read data, valid the cycle after imem_req
//   redirect      taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc   redirect target
//   instr_valid   buffer head holds an instruction
//   instr         head instruction
//   instr_pc      fetch address of the head instruction
//   instr_ready   decode accepts the head this cycle
//   fifo_count    buffer occupancy

module fetch_unit #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           imem_req,
    output logic [ADDRESS_WIDTH-1:0]       imem_addr,
    input  logic [INSTR_WIDTH-1:0]         imem_rdata,
    input  logic                           redirect,
    input  logic [ADDRESS_WIDTH-1:0]       redirect_pc,
    output logic                           instr_valid,
    output logic [INSTR_WIDTH-1:0]         instr,
    output logic [ADDRESS_WIDTH-1:0]       instr_pc,
    input  logic                           instr_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     inflight_q, inflight_d;
    logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [INSTR_WIDTH-1:0]   instr_mem_q [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0]   instr_mem_d [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem_d [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic             req;
    logic [CNT_W:0]   occupancy;

    always_comb begin
        pop = (count_q != '0) && instr_ready;

        // Entries already committed to the buffer once this cycle settles;
        // count_q >= pop whenever pop is set, so this never underflows.
        occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        req       = !rst && !redirect && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

        // A response landing in a redirect/reset cycle belongs to the
        // abandoned stream and is never written.
        push = inflight_q && !rst && !redirect;

        pc_d          = pc_q;
        inflight_d    = req;
        inflight_pc_d = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;

        if (req) begin
            pc_d = pc_q + ADDRESS_WIDTH'(4);
        end

        if (push) begin
            instr_mem_d[wr_ptr_q] = imem_rdata;
            pc_mem_d[wr_ptr_q]    = inflight_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (redirect) begin
            pc_d     = redirect_pc & ~ADDRESS_WIDTH'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            // Cleared so the head outputs read zero until the first push.
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            instr_mem_q   <= instr_mem_d;
            pc_mem_q      <= pc_mem_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  fifo_count;

    logic        imem_req8;
    logic [7:0]  imem_addr8;
    logic [31:0] imem_rdata8 = '0;
    logic        redirect8;
    logic [7:0]  redirect_pc8;
    logic        instr_valid8;
    logic [31:0] instr8;
    logic [7:0]  instr_pc8;
    logic        instr_ready8;
    logic [2:0]  fifo_count8;

    int errors = 0;
    int checks = 0;
    logic saw_40 = 1'b0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fifo_count  (fifo_count)
    );

    fetch_unit #(.ADDRESS_WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req8),
        .imem_addr   (imem_addr8),
        .imem_rdata  (imem_rdata8),
        .redirect    (redirect8),
        .redirect_pc (redirect_pc8),
        .instr_valid (instr_valid8),
        .instr       (instr8),
        .instr_pc    (instr_pc8),
        .instr_ready (instr_ready8),
        .fifo_count  (fifo_count8)
    );

    // Memory returns word = address, one cycle after the request.
    always @(posedge clk) begin
        imem_rdata  <= imem_addr;
        imem_rdata8 <= {24'h0, imem_addr8};
    end

    always @(negedge clk) begin
        if (!rst && imem_req && imem_addr == 32'h40) saw_40 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        redirect8 = 1'b0; redirect_pc8 = '0; instr_ready8 = 1'b1;
        step(); step(); #1;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc",    instr_pc, 32'd0);

        // Sequential fetch after reset release, decode always ready.
        rst = 1'b0; instr_ready = 1'b1; #1;
        chk("c0_req",   32'(imem_req), 32'd1);
        chk("c0_addr",  imem_addr, 32'h0);
        chk("c0_valid", 32'(instr_valid), 32'd0);
        step(); #1;
        chk("c1_addr",  imem_addr, 32'h4);
        chk("c1_valid", 32'(instr_valid), 32'd0);
        step(); #1;
        for (int k = 0; k < 6; k++) begin
            chk("seq_valid", 32'(instr_valid), 32'd1);
            chk("seq_pc",    instr_pc, 32'(4 * k));
            chk("seq_instr", instr, 32'(4 * k));
            step(); #1;
        end

        // Fill the buffer with decode stalled, then drain.
        rst = 1'b1; instr_ready = 1'b0;
        step(); rst = 1'b0; #1;
        chk("fill_c0_addr", imem_addr, 32'h0);
        for (int k = 0; k < 5; k++) step();
        #1;
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_req",   32'(imem_req), 32'd0);
        chk("full_pc",    instr_pc, 32'h0);
        step(); #1;
        chk("full_req2",  32'(imem_req), 32'd0);
        chk("hold_pc",    instr_pc, 32'h0);
        chk("hold_instr", instr, 32'h0);
        instr_ready = 1'b1; #1;
        chk("resume_req",  32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h10);
        for (int k = 0; k < 7; k++) begin
            chk("drain_valid", 32'(instr_valid), 32'd1);
            chk("drain_pc",    instr_pc, 32'(4 * k));
            step(); #1;
        end

        // Reset mid-operation with buffered and inflight instructions.
        rst = 1'b1; instr_ready = 1'b0; #1;
        chk("mrst_req", 32'(imem_req), 32'd0);
        step(); rst = 1'b0; #1;
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_count", 32'(fifo_count), 32'd0);
        chk("mrst_instr", instr, 32'd0);
        chk("mrst_ipc",   instr_pc, 32'd0);
        chk("mrst_req1",  32'(imem_req), 32'd1);
        chk("mrst_addr",  imem_addr, 32'h0);
        instr_ready = 1'b1;
        step(); #1;
        chk("mrst_valid1", 32'(instr_valid), 32'd0);
        step(); #1;
        chk("mrst_first_pc", instr_pc, 32'h0);
        chk("mrst_first_v",  32'(instr_valid), 32'd1);
        step(); #1;
        chk("mrst_second_pc", instr_pc, 32'h4);

        // Redirect with one response inflight and two entries buffered.
        rst = 1'b1; instr_ready = 1'b0;
        step(); rst = 1'b0;
        step(); step(); step(); #1;
        chk("pre_redir_count", 32'(fifo_count), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h103; #1;
        chk("redir_req", 32'(imem_req), 32'd0);
        step(); redirect = 1'b0; #1;
        chk("redir_count", 32'(fifo_count), 32'd0);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_req1",  32'(imem_req), 32'd1);
        chk("redir_addr",  imem_addr, 32'h100);
        step(); #1;
        chk("redir_drop_count", 32'(fifo_count), 32'd0);
        step(); #1;
        chk("redir_tgt_valid", 32'(instr_valid), 32'd1);
        chk("redir_tgt_pc",    instr_pc, 32'h100);
        chk("redir_tgt_instr", instr, 32'h100);
        chk("redir_tgt_count", 32'(fifo_count), 32'd1);

        // Back-to-back redirects: only the last target is fetched.
        saw_40 = 1'b0;
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step(); redirect_pc = 32'h80; #1;
        chk("b2b_req", 32'(imem_req), 32'd0);
        step(); redirect = 1'b0; #1;
        chk("b2b_req1", 32'(imem_req), 32'd1);
        chk("b2b_addr", imem_addr, 32'h80);
        step(); #1;
        chk("b2b_valid0", 32'(instr_valid), 32'd0);
        step(); #1;
        chk("b2b_valid", 32'(instr_valid), 32'd1);
        chk("b2b_pc",    instr_pc, 32'h80);
        chk("b2b_no40",  32'(saw_40), 32'd0);

        // 8-bit address wrap-around.
        redirect8 = 1'b1; redirect_pc8 = 8'hF8; #1;
        chk("w8_req", 32'(imem_req8), 32'd0);
        step(); redirect8 = 1'b0; #1;
        chk("w8_addr", 32'(imem_addr8), 32'hF8);
        step(); step(); #1;
        chk("w8_pc0", 32'(instr_pc8), 32'hF8);
        chk("w8_i0",  instr8, 32'hF8);
        step(); #1;
        chk("w8_pc1", 32'(instr_pc8), 32'hFC);
        step(); #1;
        chk("w8_pc2", 32'(instr_pc8), 32'h00);
        chk("w8_i2",  instr8, 32'h00);
        step(); #1;
        chk("w8_pc3", 32'(instr_pc8), 32'h04);
        chk("w8_v3",  32'(instr_valid8), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
